hash_bucket_lookup: RTL

Three-table lookup stage that sits directly upstream of the result multiplexer in the sketch datapath. It hashes each incoming 32-bit key with three independent multiplicative hashes and reads one 4-bit cell from each of three on-chip tables. It presents the three results with aligned enables, using the existing result convention: 4'hF means empty, and data is zero when idle. It also owns table initialisation and a control-plane cell update port.

---
 rtl/hash_bucket_lookup_if.sv | 32 +++
 rtl/hash_bucket_lookup.sv | 103 ++++++++++
 2 files changed

// File: rtl/hash_bucket_lookup_if.sv
// Lookup, update and result bundle for hash_bucket_lookup.
// Signal prefixes are from the lookup block's point of view.
interface hash_bucket_lookup_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [31:0]       i_key;
    logic              i_key_wr;
    logic              o_key_ready;
    logic [1:0]        i_upd_sel;
    logic [ADDR_W-1:0] i_upd_addr;
    logic [3:0]        i_upd_data;
    logic              i_upd_wr;
    logic [3:0]        o_hash_rdata1;
    logic [3:0]        o_hash_rdata2;
    logic [3:0]        o_hash_rdata3;
    logic              o_hash_rdata1_wr;
    logic              o_hash_rdata2_wr;
    logic              o_hash_rdata3_wr;
    logic [15:0]       o_drop_cnt;

    modport master (
        output i_key, i_key_wr, i_upd_sel, i_upd_addr, i_upd_data, i_upd_wr,
        input  o_key_ready, o_hash_rdata1, o_hash_rdata2, o_hash_rdata3,
               o_hash_rdata1_wr, o_hash_rdata2_wr, o_hash_rdata3_wr, o_drop_cnt
    );

    modport slave (
        input  i_key, i_key_wr, i_upd_sel, i_upd_addr, i_upd_data, i_upd_wr,
        output o_key_ready, o_hash_rdata1, o_hash_rdata2, o_hash_rdata3,
               o_hash_rdata1_wr, o_hash_rdata2_wr, o_hash_rdata3_wr, o_drop_cnt
    );
endinterface

// File: rtl/hash_bucket_lookup.sv
// Three-table multiplicative-hash lookup with 2-cycle latency, table
// initialisation to 4'hF after reset and a control-plane cell update port.
module hash_bucket_lookup #(
    parameter int unsigned ADDR_W = 10,
    parameter logic [31:0] SEED1  = 32'h9E3779B1,
    parameter logic [31:0] SEED2  = 32'h85EBCA77,
    parameter logic [31:0] SEED3  = 32'hC2B2AE3D
) (
    input  logic                 i_sys_clk,
    input  logic                 i_rst,
    hash_bucket_lookup_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [2:0][31:0] SEEDS = {SEED3, SEED2, SEED1};

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_init_addr;
    logic [ADDR_W-1:0] w_init_addr_next;
    logic              w_key_ready;
    logic              w_accept;
    logic              r_s1_valid;
    logic              r_s2_valid;
    logic [15:0]       r_drop_cnt;

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_INIT;
            r_init_addr <= '0;
        end else begin
            r_state     <= w_state_next;
            r_init_addr <= w_init_addr_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_init_addr_next = r_init_addr;
        if (r_state == S_INIT) begin
            w_init_addr_next = r_init_addr + 1'b1;
            if (&r_init_addr) begin
                w_state_next = S_RUN;
            end
        end
    end

    // Ready comes straight from the state register, so a key on the rising edge is still dropped.
    assign w_key_ready = (r_state == S_RUN);
    assign w_accept    = bus.i_key_wr & w_key_ready;

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_s1_valid <= w_accept;
            r_s2_valid <= r_s1_valid;
            if (bus.i_key_wr && !w_key_ready && r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_tbl
            logic [3:0]        r_mem [DEPTH];
            logic [3:0]        r_rd;
            logic [ADDR_W-1:0] r_h;
            logic [ADDR_W-1:0] w_hash;
            logic              w_we;
            logic [ADDR_W-1:0] w_waddr;
            logic [3:0]        w_wdata;

            assign w_hash  = ADDR_W'((bus.i_key * SEEDS[gi]) >> (32 - ADDR_W));
            assign w_we    = (r_state == S_INIT) ||
                             (bus.i_upd_wr && bus.i_upd_sel == 2'(gi + 1));
            assign w_waddr = (r_state == S_INIT) ? r_init_addr : bus.i_upd_addr;
            assign w_wdata = (r_state == S_INIT) ? 4'hF : bus.i_upd_data;

            // Non-blocking read and write on the same edge give read-first behaviour.
            always_ff @(posedge i_sys_clk) begin
                if (w_we) begin
                    r_mem[w_waddr] <= w_wdata;
                end
                r_h  <= w_hash;
                r_rd <= r_mem[r_h];
            end
        end
    endgenerate

    assign bus.o_key_ready      = w_key_ready;
    assign bus.o_drop_cnt       = r_drop_cnt;
    assign bus.o_hash_rdata1    = r_s2_valid ? g_tbl[0].r_rd : 4'h0;
    assign bus.o_hash_rdata2    = r_s2_valid ? g_tbl[1].r_rd : 4'h0;
    assign bus.o_hash_rdata3    = r_s2_valid ? g_tbl[2].r_rd : 4'h0;
    assign bus.o_hash_rdata1_wr = r_s2_valid;
    assign bus.o_hash_rdata2_wr = r_s2_valid;
    assign bus.o_hash_rdata3_wr = r_s2_valid;
endmodule
